// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment lookup for the 7-segment scan driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        return SEG7_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = seg7_decode(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: one digit per mux_en edge, blank gap between
// digits, optional leading-zero suppression, frame-aligned data updates.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mux_en,
    input  logic [4*NUM_DIGITS-1:0]       data_i,
    input  logic [NUM_DIGITS-1:0]         dp_i,
    input  logic                          data_valid_i,
    input  logic                          lz_blank_i,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic [6:0]                    seg_o,
    output logic                          dp_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic             INV      = ACTIVE_LOW;

    scan_state_t           state_reg, state_next;
    logic                  mux_en_q_reg;
    logic                  tick;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [DATA_W-1:0]     shadow_reg, disp_reg, disp_next, load_data;
    logic [NUM_DIGITS-1:0] shadow_dp_reg, disp_dp_reg, disp_dp_next, load_dp;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic [6:0]            seg_reg, seg_next;
    logic                  dp_reg, dp_next;
    logic                  frame_load, enter_show, go_dark, lz_hide;
    logic [3:0]            nibble;
    logic [6:0]            seg_decoded;
    logic [NUM_DIGITS-1:0] upper_zero;

    assign tick = mux_en ^ mux_en_q_reg;

    // A strobe landing on the frame-load cycle bypasses the shadow.
    assign load_data = data_valid_i ? data_i : shadow_reg;
    assign load_dp   = data_valid_i ? dp_i   : shadow_dp_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        frame_load = 1'b0;
        enter_show = 1'b0;
        go_dark    = 1'b0;
        case (state_reg)
            OFF: begin
                if (tick) begin
                    state_next = SHOW;
                    idx_next   = '0;
                    frame_load = 1'b1;
                    enter_show = 1'b1;
                end
            end
            SHOW: begin
                if (tick) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    go_dark    = 1'b1;
                end
            end
            BLANK: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = SHOW;
                    enter_show = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        frame_load = 1'b1;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = OFF;
        endcase
    end

    assign disp_next    = frame_load ? load_data : disp_reg;
    assign disp_dp_next = frame_load ? load_dp   : disp_dp_reg;
    assign nibble       = disp_next[{idx_next, 2'b00} +: 4];

    // upper_zero[i]: every nibble from the leftmost digit down to digit i is zero.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
        assign upper_zero[gi] = ~|disp_next[DATA_W-1:4*gi];
    end

    assign lz_hide = lz_blank_i && (idx_next != '0) && upper_zero[idx_next];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (seg_decoded)
    );

    // Outputs are built active-high, then polarity-flipped into the register.
    always_comb begin
        an_next  = an_reg;
        seg_next = seg_reg;
        dp_next  = dp_reg;
        if (enter_show) begin
            an_next  = {NUM_DIGITS{INV}} ^ (NUM_DIGITS'(1) << idx_next);
            seg_next = {7{INV}} ^ (lz_hide ? 7'h00 : seg_decoded);
            dp_next  = INV ^ disp_dp_next[idx_next];
        end else if (go_dark) begin
            an_next  = {NUM_DIGITS{INV}};
            seg_next = {7{INV}};
            dp_next  = INV;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= OFF;
            mux_en_q_reg  <= 1'b0;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shadow_reg    <= '0;
            shadow_dp_reg <= '0;
            disp_reg      <= '0;
            disp_dp_reg   <= '0;
            an_reg        <= {NUM_DIGITS{INV}};
            seg_reg       <= {7{INV}};
            dp_reg        <= INV;
        end else begin
            state_reg    <= state_next;
            mux_en_q_reg <= mux_en;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            disp_reg     <= disp_next;
            disp_dp_reg  <= disp_dp_next;
            an_reg       <= an_next;
            seg_reg      <= seg_next;
            dp_reg       <= dp_next;
            if (data_valid_i) begin
                shadow_reg    <= data_i;
                shadow_dp_reg <= dp_i;
            end
        end
    end

    assign an_o        = an_reg;
    assign seg_o       = seg_reg;
    assign dp_o        = dp_reg;
    assign digit_idx_o = idx_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 16 blank cycles, active-low).
// Expected displays are queued when stimulus is driven and checked when shown.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int BC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mux_en;
    logic [15:0] data_i;
    logic [3:0]  dp_i;
    logic        data_valid_i;
    logic        lz_blank_i;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [1:0]  digit_idx_o;

    always #50 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS   (ND),
        .BLANK_CYCLES (BC),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mux_en       (mux_en),
        .data_i       (data_i),
        .dp_i         (dp_i),
        .data_valid_i (data_valid_i),
        .lz_blank_i   (lz_blank_i),
        .an_o         (an_o),
        .seg_o        (seg_o),
        .dp_o         (dp_o),
        .digit_idx_o  (digit_idx_o)
    );

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
    } exp_t;

    exp_t        sb_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] m_shadow, m_disp;
    logic [3:0]  m_shadow_dp, m_disp_dp;
    int          m_idx;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_show(input string tag);
        exp_t e;
        logic hide;
        hide  = lz_blank_i && (m_idx > 0) && ((m_disp >> (4 * m_idx)) == 16'h0);
        e.tag = tag;
        e.an  = ~(4'b0001 << m_idx);
        e.seg = hide ? 7'h7F : ~ref_seg(m_disp[m_idx*4 +: 4]);
        e.dp  = ~m_disp_dp[m_idx];
        e.idx = 2'(m_idx);
        sb_q.push_back(e);
    endtask

    task automatic push_dark(input string tag);
        exp_t e;
        e.tag = tag;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.idx = 2'(m_idx);
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL sb_underflow: observed empty queue expected an entry");
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, "/an"},  32'(an_o),        32'(e.an));
        check({e.tag, "/seg"}, 32'(seg_o),       32'(e.seg));
        check({e.tag, "/dp"},  32'(dp_o),        32'(e.dp));
        check({e.tag, "/idx"}, 32'(digit_idx_o), 32'(e.idx));
    endtask

    task automatic strobe(input logic [15:0] d, input logic [3:0] dp);
        @(negedge clk);
        data_i       = d;
        dp_i         = dp;
        data_valid_i = 1'b1;
        m_shadow     = d;
        m_shadow_dp  = dp;
        @(negedge clk);
        data_valid_i = 1'b0;
    endtask

    task automatic tick_from_off(input string tag);
        @(negedge clk);
        mux_en    = ~mux_en;
        m_idx     = 0;
        m_disp    = m_shadow;
        m_disp_dp = m_shadow_dp;
        push_show(tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    // From SHOW: toggle, require exactly BC dark cycles, then the next digit.
    task automatic step(input string tag, input bit coinc, input logic [15:0] cdata,
                        input logic [3:0] cdp, input bit blank_tick);
        logic blank_ok;
        @(negedge clk);
        mux_en   = ~mux_en;
        blank_ok = 1'b1;
        for (int i = 0; i < BC; i++) begin
            @(posedge clk);
            #1;
            if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || digit_idx_o !== 2'(m_idx))
                blank_ok = 1'b0;
            if (blank_tick && i == 5) mux_en = ~mux_en;
            if (coinc && i == BC - 1) begin
                data_i       = cdata;
                dp_i         = cdp;
                data_valid_i = 1'b1;
                m_shadow     = cdata;
                m_shadow_dp  = cdp;
            end
        end
        check({tag, "/blank_gap"}, 32'(blank_ok), 32'(1));
        m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
        if (m_idx == 0) begin
            m_disp    = m_shadow;
            m_disp_dp = m_shadow_dp;
        end
        push_show(tag);
        @(posedge clk);
        #1;
        data_valid_i = 1'b0;
        pop_check();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        mux_en       = 1'b0;
        data_i       = '0;
        dp_i         = '0;
        data_valid_i = 1'b0;
        lz_blank_i   = 1'b0;
        m_shadow     = '0;
        m_shadow_dp  = '0;
        m_disp       = '0;
        m_disp_dp    = '0;
        m_idx        = 0;

        repeat (3) @(posedge clk);
        #1;
        push_dark("reset");
        pop_check();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        push_dark("idle_no_tick");
        pop_check();

        strobe(16'h12AF, 4'b0101);
        tick_from_off("scan_first");
        for (int k = 0; k < 7; k++) step("scan", 1'b0, 16'h0, 4'h0, 1'b0);

        strobe(16'h0005, 4'b0000);
        lz_blank_i = 1'b1;
        repeat (4) step("lz_on", 1'b0, 16'h0, 4'h0, 1'b0);
        lz_blank_i = 1'b0;
        repeat (4) step("lz_off", 1'b0, 16'h0, 4'h0, 1'b0);

        strobe(16'h1111, 4'b0000);
        repeat (3) step("tear_old", 1'b0, 16'h0, 4'h0, 1'b0);
        strobe(16'h2222, 4'b1000);
        step("tear_hold", 1'b0, 16'h0, 4'h0, 1'b0);
        step("tear_new", 1'b0, 16'h0, 4'h0, 1'b0);
        repeat (3) step("frame2", 1'b0, 16'h0, 4'h0, 1'b0);
        step("coincident", 1'b1, 16'h3333, 4'b0001, 1'b0);

        step("blank_tick", 1'b0, 16'h0, 4'h0, 1'b1);
        step("after_blank_tick", 1'b0, 16'h0, 4'h0, 1'b0);

        @(negedge clk);
        rst         = 1'b1;
        mux_en      = 1'b0;
        m_idx       = 0;
        m_shadow    = '0;
        m_shadow_dp = '0;
        m_disp      = '0;
        m_disp_dp   = '0;
        push_dark("midscan_reset");
        @(posedge clk);
        #1;
        pop_check();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_dark("post_reset_idle");
        pop_check();
        tick_from_off("restart");
        step("restart_next", 1'b0, 16'h0, 4'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
